// File: rtl/hs32_wb_arbiter.sv
// hs32 write-back arbiter and load scoreboard.
// Shares the banked register file's single write port between the execute
// result path (EX) and the load return path (LD), maps (bank, addr) onto the
// two bank write enables, and tracks registers with loads still in flight so
// decode can stall on read-after-write hazards.
module hs32_wb_arbiter #(
    parameter bit LD_FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [3:0]  ex_addr_i,
    input  logic        ex_bank_i,
    input  logic [31:0] ex_data_i,

    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [3:0]  ld_addr_i,
    input  logic        ld_bank_i,
    input  logic [31:0] ld_data_i,

    input  logic        sb_set_i,
    input  logic [3:0]  sb_addr_i,
    input  logic        sb_bank_i,

    input  logic        q_bank_i,
    input  logic [3:0]  q1_addr_i,
    input  logic [3:0]  q2_addr_i,
    output logic        q1_busy_o,
    output logic        q2_busy_o,
    output logic        sb_err_o,

    output logic [3:0]  wp1_addr_o,
    output logic [31:0] wp1_data_o,
    output logic        wp1_we1_o,
    output logic        wp1_we2_o
);

    // Which requester won the most recent conflict.
    typedef enum logic {
        RR_EX = 1'b0,
        RR_LD = 1'b1
    } rr_t;

    // Scoreboard index: 0..15 main bank (includes unbanked r8-r15 of the
    // supervisor view), 16..23 supervisor r0-r7.
    function automatic logic [4:0] f_sb_idx(input logic bank, input logic [3:0] addr);
        return (bank && !addr[3]) ? {2'b10, addr[2:0]} : {1'b0, addr};
    endfunction

    rr_t         r_rr_last;
    logic [23:0] r_sb;
    logic        r_sb_err;
    logic        r_we1;
    logic        r_we2;
    logic [3:0]  r_addr;
    logic [31:0] r_data;

    logic        w_ex_gnt;
    logic        w_ld_gnt;
    logic        w_conflict;
    logic        w_any_gnt;
    logic        w_sel_bank;
    logic [3:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic [4:0]  w_ld_idx;
    logic [4:0]  w_set_idx;
    logic [23:0] w_sb_next;
    logic        w_set_err;

    assign w_conflict = ex_valid_i && ld_valid_i;
    assign w_any_gnt  = w_ex_gnt || w_ld_gnt;
    assign w_ld_idx   = f_sb_idx(ld_bank_i, ld_addr_i);
    assign w_set_idx  = f_sb_idx(sb_bank_i, sb_addr_i);

    // Grant: lone requester wins; on conflict LD wins in fixed mode,
    // otherwise the side that did not win the previous conflict.
    always_comb begin
        w_ex_gnt = 1'b0;
        w_ld_gnt = 1'b0;
        if (w_conflict) begin
            if (LD_FIXED_PRIO)
                w_ld_gnt = 1'b1;
            else if (r_rr_last == RR_LD)
                w_ex_gnt = 1'b1;
            else
                w_ld_gnt = 1'b1;
        end else begin
            w_ex_gnt = ex_valid_i;
            w_ld_gnt = ld_valid_i;
        end
    end

    // Mux the granted request onto the write path.
    always_comb begin
        w_sel_bank = ex_bank_i;
        w_sel_addr = ex_addr_i;
        w_sel_data = ex_data_i;
        if (w_ld_gnt) begin
            w_sel_bank = ld_bank_i;
            w_sel_addr = ld_addr_i;
            w_sel_data = ld_data_i;
        end
    end

    // Scoreboard update: the LD clear is applied first so a same-cycle set
    // of the same entry keeps it busy (back-to-back loads to one register).
    always_comb begin
        w_sb_next = r_sb;
        if (w_ld_gnt)
            w_sb_next[w_ld_idx] = 1'b0;
        if (sb_set_i)
            w_sb_next[w_set_idx] = 1'b1;
    end

    assign w_set_err = sb_set_i && r_sb[w_set_idx] &&
                       !(w_ld_gnt && (w_ld_idx == w_set_idx));

    // Registered write port; address/data hold while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we1  <= 1'b0;
            r_we2  <= 1'b0;
            r_addr <= 4'd0;
            r_data <= 32'd0;
        end else begin
            r_we1 <= w_any_gnt && (!w_sel_bank || w_sel_addr[3]);
            r_we2 <= w_any_gnt && w_sel_bank && !w_sel_addr[3];
            if (w_any_gnt) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    // Round-robin history moves only when both sides competed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rr_last <= RR_LD;
        else if (w_conflict)
            r_rr_last <= w_ld_gnt ? RR_LD : RR_EX;
    end

    // Scoreboard bits and the sticky double-set error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb     <= 24'd0;
            r_sb_err <= 1'b0;
        end else begin
            r_sb <= w_sb_next;
            if (w_set_err)
                r_sb_err <= 1'b1;
        end
    end

    assign ex_ready_o = w_ex_gnt;
    assign ld_ready_o = w_ld_gnt;
    assign q1_busy_o  = r_sb[f_sb_idx(q_bank_i, q1_addr_i)];
    assign q2_busy_o  = r_sb[f_sb_idx(q_bank_i, q2_addr_i)];
    assign sb_err_o   = r_sb_err;
    assign wp1_we1_o  = r_we1;
    assign wp1_we2_o  = r_we2;
    assign wp1_addr_o = r_addr;
    assign wp1_data_o = r_data;

endmodule

// File: tb/tb_hs32_wb_arbiter.sv
// Scoreboard bench for hs32_wb_arbiter: the driver pushes each expected
// register-file write with the cycle it must appear in; a monitor on the
// falling edge pops and compares. A second instance in fixed-priority mode
// shares the inputs and is checked for its grant pattern.
module tb_hs32_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid_i = 0, ld_valid_i = 0, sb_set_i = 0;
    logic [3:0]  ex_addr_i = 0, ld_addr_i = 0, sb_addr_i = 0;
    logic        ex_bank_i = 0, ld_bank_i = 0, sb_bank_i = 0, q_bank_i = 0;
    logic [31:0] ex_data_i = 0, ld_data_i = 0;
    logic [3:0]  q1_addr_i = 0, q2_addr_i = 0;

    logic        ex_ready_o, ld_ready_o, q1_busy_o, q2_busy_o, sb_err_o;
    logic [3:0]  wp1_addr_o;
    logic [31:0] wp1_data_o;
    logic        wp1_we1_o, wp1_we2_o;

    logic        f_ex_ready, f_ld_ready, f_q1_busy, f_q2_busy, f_sb_err;
    logic [3:0]  f_addr;
    logic [31:0] f_data;
    logic        f_we1, f_we2;

    typedef struct {
        int          due;
        logic        we1;
        logic        we2;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    hs32_wb_arbiter #(.LD_FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_addr_i(ex_addr_i),
        .ex_bank_i(ex_bank_i), .ex_data_i(ex_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
        .ld_bank_i(ld_bank_i), .ld_data_i(ld_data_i),
        .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i), .sb_bank_i(sb_bank_i),
        .q_bank_i(q_bank_i), .q1_addr_i(q1_addr_i), .q2_addr_i(q2_addr_i),
        .q1_busy_o(q1_busy_o), .q2_busy_o(q2_busy_o), .sb_err_o(sb_err_o),
        .wp1_addr_o(wp1_addr_o), .wp1_data_o(wp1_data_o),
        .wp1_we1_o(wp1_we1_o), .wp1_we2_o(wp1_we2_o)
    );

    hs32_wb_arbiter #(.LD_FIXED_PRIO(1'b1)) dut_fix (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_ready_o(f_ex_ready), .ex_addr_i(ex_addr_i),
        .ex_bank_i(ex_bank_i), .ex_data_i(ex_data_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(f_ld_ready), .ld_addr_i(ld_addr_i),
        .ld_bank_i(ld_bank_i), .ld_data_i(ld_data_i),
        .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i), .sb_bank_i(sb_bank_i),
        .q_bank_i(q_bank_i), .q1_addr_i(q1_addr_i), .q2_addr_i(q2_addr_i),
        .q1_busy_o(f_q1_busy), .q2_busy_o(f_q2_busy), .sb_err_o(f_sb_err),
        .wp1_addr_o(f_addr), .wp1_data_o(f_data),
        .wp1_we1_o(f_we1), .wp1_we2_o(f_we2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_wr(input logic we1, input logic we2, input logic [3:0] addr,
                           input logic [31:0] data);
        wr_t w;
        w.due  = cyc + 1;
        w.we1  = we1;
        w.we2  = we2;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write seen on the port must match the oldest expected
    // write due this cycle; expected writes that never show up are flagged.
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_chk++;
                $display("FAIL missed_write: addr 0x%0h data 0x%0h never seen",
                         exp_q[0].addr, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (wp1_we1_o || wp1_we2_o) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    chk("write_port", {26'd0, wp1_we1_o, wp1_we2_o, wp1_addr_o, wp1_data_o},
                        {26'd0, exp_q[0].we1, exp_q[0].we2, exp_q[0].addr, exp_q[0].data});
                    void'(exp_q.pop_front());
                end else begin
                    n_chk++;
                    $display("FAIL unexpected_write: we1 %0b we2 %0b addr 0x%0h data 0x%0h expected none",
                             wp1_we1_o, wp1_we2_o, wp1_addr_o, wp1_data_o);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                n_chk++;
                $display("FAIL missing_write: no enable, expected addr 0x%0h data 0x%0h",
                         exp_q[0].addr, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        #2;
        chk("rst_we", {wp1_we1_o, wp1_we2_o}, 2'b00);
        chk("rst_addr_data", {wp1_addr_o, wp1_data_o}, 36'd0);
        chk("rst_err", sb_err_o, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // EX alone, bank 0 r3.
        ex_valid_i = 1; ex_addr_i = 4'd3; ex_bank_i = 0; ex_data_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("ex_alone_rdy", {ex_ready_o, ld_ready_o}, 2'b10);
        push_wr(1, 0, 4'd3, 32'hDEADBEEF);
        tick();

        // Supervisor bank r5 -> we2; supervisor r12 is unbanked -> we1.
        ex_addr_i = 4'd5; ex_bank_i = 1; ex_data_i = 32'h0000_0005;
        @(negedge clk);
        push_wr(0, 1, 4'd5, 32'h0000_0005);
        tick();
        ex_addr_i = 4'd12; ex_bank_i = 1; ex_data_i = 32'h0000_000C;
        @(negedge clk);
        push_wr(1, 0, 4'd12, 32'h0000_000C);
        tick();
        ex_valid_i = 0; ex_bank_i = 0;
        tick();

        // Four conflict cycles: round robin gives EX, LD, EX, LD; fixed gives LD.
        for (int i = 0; i < 4; i++) begin
            ex_valid_i = 1; ex_addr_i = 4'd1; ex_data_i = 32'h100 + i;
            ld_valid_i = 1; ld_addr_i = 4'd2; ld_bank_i = 0; ld_data_i = 32'h200 + i;
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("rr_grant", {ex_ready_o, ld_ready_o}, 2'b10);
                push_wr(1, 0, 4'd1, 32'h100 + i);
            end else begin
                chk("rr_grant", {ex_ready_o, ld_ready_o}, 2'b01);
                push_wr(1, 0, 4'd2, 32'h200 + i);
            end
            chk("fixed_grant", {f_ex_ready, f_ld_ready}, 2'b01);
            tick();
        end
        ex_valid_i = 0; ld_valid_i = 0;
        tick();

        // Scoreboard set of r7 bank 0.
        sb_set_i = 1; sb_addr_i = 4'd7; sb_bank_i = 0;
        tick();
        sb_set_i = 0;
        q_bank_i = 0; q1_addr_i = 4'd7; q2_addr_i = 4'd6;
        #1;
        chk("sb_busy_r7", {q1_busy_o, q2_busy_o}, 2'b10);
        q_bank_i = 1;
        #1;
        chk("sb_busy_r7_sup", q1_busy_o, 1'b0);
        q_bank_i = 0;

        // LD write-back to r7 clears busy at the registering edge.
        ld_valid_i = 1; ld_addr_i = 4'd7; ld_bank_i = 0; ld_data_i = 32'h77;
        @(negedge clk);
        chk("ld_alone_rdy", {ex_ready_o, ld_ready_o, q1_busy_o}, 3'b011);
        push_wr(1, 0, 4'd7, 32'h77);
        tick();
        ld_valid_i = 0;
        #1;
        chk("sb_clear_r7", q1_busy_o, 1'b0);

        // Set r7, then set and clear r7 together: stays busy, no error.
        sb_set_i = 1;
        tick();
        ld_valid_i = 1; ld_data_i = 32'h78;
        @(negedge clk);
        chk("setclr_rdy", ld_ready_o, 1'b1);
        push_wr(1, 0, 4'd7, 32'h78);
        tick();
        sb_set_i = 0; ld_valid_i = 0;
        #1;
        chk("setclr_busy_err", {q1_busy_o, sb_err_o}, 2'b10);

        // Second set while busy: sticky error.
        sb_set_i = 1;
        tick();
        sb_set_i = 0;
        #1;
        chk("double_set", {q1_busy_o, sb_err_o}, 2'b11);
        tick();
        chk("err_sticky", sb_err_o, 1'b1);

        // Reset in the middle of a registered write.
        ex_valid_i = 1; ex_addr_i = 4'd9; ex_bank_i = 0; ex_data_i = 32'h99;
        @(negedge clk);
        push_wr(1, 0, 4'd9, 32'h99);
        tick();
        ex_valid_i = 0;
        chk("pre_reset_we", {wp1_we1_o, wp1_we2_o, wp1_addr_o}, 6'b10_1001);
        reset = 1;
        #1;
        chk("async_rst_we", {wp1_we1_o, wp1_we2_o}, 2'b00);
        chk("async_rst_sb", {q1_busy_o, sb_err_o, wp1_addr_o}, 6'd0);
        exp_q.delete();
        tick();
        reset = 0;
        tick();

        // Round robin restarts with EX winning the first conflict.
        ex_valid_i = 1; ex_addr_i = 4'd1; ex_data_i = 32'hA1;
        ld_valid_i = 1; ld_addr_i = 4'd2; ld_data_i = 32'hA2;
        @(negedge clk);
        chk("rr_after_reset", {ex_ready_o, ld_ready_o}, 2'b10);
        push_wr(1, 0, 4'd1, 32'hA1);
        tick();
        ex_valid_i = 0; ld_valid_i = 0;
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
